// File: rtl/aurora_crc16_pkg.sv
// Shared CRC16 arithmetic and frame-state encoding for the Aurora dual-CRC16
// transmit inserter and its receive-side checker.
package aurora_crc16_pkg;

  localparam logic [15:0] CRC_POLY_DEFAULT = 16'h1021;
  localparam logic [15:0] CRC_INIT_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } frame_state_t;

  // Non-reflected, MSB-first: sixteen serial LFSR shifts folded into one call.
  function automatic logic [15:0] crc16_step16(
    input logic [15:0] crc,
    input logic [15:0] data,
    input logic [15:0] poly
  );
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_lane.sv
// One CRC16 lane: combinational next-CRC feeding a register with
// synchronous clear (priority) and enable.
module crc16_lane
  import aurora_crc16_pkg::*;
#(
  parameter logic [15:0] CRC_POLY = CRC_POLY_DEFAULT,
  parameter logic [15:0] CRC_INIT = CRC_INIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] crc
);

  logic [15:0] crc_next;

  assign crc_next = crc16_step16(crc, data, CRC_POLY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/aurora_dual_crc16_insert.sv
// Aurora TX dual-CRC16 inserter: forwards 32-bit frame words through one
// output register and appends {crc_a, crc_b} as the tlast word.
module aurora_dual_crc16_insert
  import aurora_crc16_pkg::*;
#(
  parameter logic [15:0] CRC_POLY = CRC_POLY_DEFAULT,
  parameter logic [15:0] CRC_INIT = CRC_INIT_DEFAULT
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        channel_up,
  input  logic [0:31] s_axis_tdata,
  input  logic [0:3]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [0:31] m_axis_tdata,
  output logic [0:3]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  frame_state_t state;
  logic         out_free;
  logic         accept;
  logic         crc_emit;
  logic         crc_clr;
  logic [15:0]  crc_a;
  logic [15:0]  crc_b;
  logic         tkeep_unused;

  // Every beat is treated as a full word regardless of tkeep.
  assign tkeep_unused = ^s_axis_tkeep;
  assign m_axis_tkeep = 4'hF;

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = aresetn && channel_up && (state != CRC) && out_free;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign crc_emit      = channel_up && (state == CRC) && out_free;
  assign crc_clr       = !channel_up || crc_emit;

  crc16_lane #(.CRC_POLY(CRC_POLY), .CRC_INIT(CRC_INIT)) u_lane_a (
    .clk   (aclk),
    .rst_n (aresetn),
    .clr   (crc_clr),
    .en    (accept),
    .data  (s_axis_tdata[0:15]),
    .crc   (crc_a)
  );

  crc16_lane #(.CRC_POLY(CRC_POLY), .CRC_INIT(CRC_INIT)) u_lane_b (
    .clk   (aclk),
    .rst_n (aresetn),
    .clr   (crc_clr),
    .en    (accept),
    .data  (s_axis_tdata[16:31]),
    .crc   (crc_b)
  );

  // Output register stage and frame FSM; a channel drop discards the pending word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (!channel_up) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (accept) begin
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b1;
      state         <= s_axis_tlast ? CRC : DATA;
    end else if (crc_emit) begin
      m_axis_tdata  <= {crc_a, crc_b};
      m_axis_tlast  <= 1'b1;
      m_axis_tvalid <= 1'b1;
      state         <= IDLE;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aurora_dual_crc16_insert.sv
// Self-checking bench for aurora_dual_crc16_insert: directed steps plus random
// frames scored against a polynomial long-division CRC model.
module tb_aurora_dual_crc16_insert;

  localparam logic [16:0] GEN_POLY = 17'h11021;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        channel_up;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;

  logic rand_mode;
  logic fixed_ready;
  logic rnd_ready;
  wire  m_tready = rand_mode ? rnd_ready : fixed_ready;

  int          n_assert;
  int          n_fail;
  logic [32:0] exp_q[$];
  logic        mon_en;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [31:0] last_crc_word;

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  aurora_dual_crc16_insert dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .channel_up    (channel_up),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // CRC as remainder of (M*x^16 + INIT*x^len) mod G, done by bitwise long division.
  function automatic logic [15:0] model_crc(input logic [15:0] hws[$]);
    bit          m[$];
    logic [15:0] r;
    int          n;
    foreach (hws[k])
      for (int b = 15; b >= 0; b--) m.push_back(hws[k][b]);
    for (int b = 0; b < 16; b++) m[b] = m[b] ^ 1'b1;
    for (int b = 0; b < 16; b++) m.push_back(1'b0);
    n = m.size();
    for (int i = 0; i < n - 16; i++)
      if (m[i])
        for (int j = 0; j < 17; j++) m[i + j] = m[i + j] ^ GEN_POLY[16 - j];
    for (int b = 0; b < 16; b++) r[15 - b] = m[n - 16 + b];
    return r;
  endfunction

  // Scoreboard monitor: output order, CRC words, tkeep, and stability under stall.
  always @(negedge aclk) begin
    logic [32:0] e;
    if (mon_en && aresetn) begin
      if (prev_stall) begin
        check("stall_valid", 32'(m_tvalid), 32'd1);
        check("stall_data", m_tdata, prev_data);
        check("stall_last", 32'(m_tlast), 32'(prev_last));
      end
      if (m_tvalid && m_tready) begin
        check("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", m_tdata, e[31:0]);
          check("out_last", 32'(m_tlast), 32'(e[32]));
          check("out_keep", 32'(m_tkeep), 32'hF);
          if (m_tlast) last_crc_word = m_tdata;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic drive_word(input logic [31:0] d, input logic last);
    int t;
    t = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_tready && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 2000) check("accept_timeout", 32'(s_tready), 32'd1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] fr[$], input bit gaps);
    logic [15:0] ha[$];
    logic [15:0] hb[$];
    foreach (fr[i]) begin
      ha.push_back(fr[i][31:16]);
      hb.push_back(fr[i][15:0]);
      exp_q.push_back({1'b0, fr[i]});
    end
    exp_q.push_back({1'b1, model_crc(ha), model_crc(hb)});
    foreach (fr[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge aclk);
        #1;
      end
      drive_word(fr[i], i == fr.size() - 1);
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge aclk);
      t++;
    end
    check(tag, exp_q.size(), 0);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, observed unfinished expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] fr[$];
    int          len;
    n_assert    = 0;
    n_fail      = 0;
    mon_en      = 1'b0;
    prev_stall  = 1'b0;
    rand_mode   = 1'b0;
    fixed_ready = 1'b1;
    rnd_ready   = 1'b0;
    aresetn     = 1'b0;
    channel_up  = 1'b1;
    s_tdata     = '0;
    s_tkeep     = 4'hF;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    last_crc_word = '0;

    // Reset state
    repeat (3) @(posedge aclk);
    #2;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tdata", m_tdata, 32'h0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    mon_en = 1'b1;

    // Test 1: single zero word
    exp_q.push_back({1'b0, 32'h0000_0000});
    exp_q.push_back({1'b1, 32'h1D0F_1D0F});
    s_tdata  = 32'h0;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    @(negedge aclk);
    check("t1_ready_idle", 32'(s_tready), 32'd1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    check("t1_word_valid", 32'(m_tvalid), 32'd1);
    check("t1_word_data", m_tdata, 32'h0);
    check("t1_word_last", 32'(m_tlast), 32'd0);
    check("t1_bubble", 32'(s_tready), 32'd0);
    @(posedge aclk);
    #1;
    check("t1_crc_data", m_tdata, 32'h1D0F_1D0F);
    check("t1_crc_last", 32'(m_tlast), 32'd1);
    check("t1_ready_back", 32'(s_tready), 32'd1);
    drain("t1_drain");

    // Test 2: back-to-back 4- and 2-word frames
    fr = {};
    for (int i = 0; i < 4; i++) fr.push_back($urandom);
    send_frame(fr, 1'b0);
    fr = {};
    for (int i = 0; i < 2; i++) fr.push_back($urandom);
    send_frame(fr, 1'b0);
    drain("t2_drain");

    // Test 4: lanes see different halfwords
    fr = {32'h1234_0000, 32'h0000_ABCD};
    send_frame(fr, 1'b0);
    drain("t4_drain");
    check("t4_lanes_differ", 32'(last_crc_word[31:16] != last_crc_word[15:0]), 32'd1);

    // Test 3: random backpressure, random frame lengths
    rand_mode = 1'b1;
    for (int f = 0; f < 300; f++) begin
      len = $urandom_range(1, 64);
      fr = {};
      for (int i = 0; i < len; i++) fr.push_back($urandom);
      send_frame(fr, 1'b1);
    end
    drain("t3_drain");
    rand_mode   = 1'b0;
    fixed_ready = 1'b1;

    // Test 5: channel drop mid-frame with word 2 held in the output register
    mon_en = 1'b0;
    @(posedge aclk);
    #1;
    drive_word($urandom, 1'b0);
    drive_word($urandom, 1'b0);
    fixed_ready = 1'b0;
    channel_up  = 1'b0;
    #1;
    check("t5_ready_drop", 32'(s_tready), 32'd0);
    check("t5_valid_held", 32'(m_tvalid), 32'd1);
    @(posedge aclk);
    #1;
    check("t5_valid_cleared", 32'(m_tvalid), 32'd0);
    check("t5_last_cleared", 32'(m_tlast), 32'd0);
    repeat (4) begin
      check("t5_ready_low", 32'(s_tready), 32'd0);
      @(posedge aclk);
      #1;
    end
    channel_up  = 1'b1;
    fixed_ready = 1'b1;
    mon_en      = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    fr = {32'h0};
    send_frame(fr, 1'b0);
    drain("t5_drain");
    check("t5_clean_crc", last_crc_word, 32'h1D0F_1D0F);

    // Test 6: asynchronous reset while stalled in the CRC state
    mon_en      = 1'b0;
    fixed_ready = 1'b0;
    drive_word($urandom, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    check("t6_valid_async", 32'(m_tvalid), 32'd0);
    check("t6_data_async", m_tdata, 32'h0);
    check("t6_ready_rst", 32'(s_tready), 32'd0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    fixed_ready = 1'b1;
    mon_en      = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    check("t6_no_stale_out", 32'(m_tvalid), 32'd0);
    fr = {};
    for (int i = 0; i < 3; i++) fr.push_back($urandom);
    send_frame(fr, 1'b0);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
